// File: rtl/rand_arb_pkg.sv
// Shared types and LFSR helpers for the arbitrated random-byte server.
package rand_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_TAP      = 8'b0001_1101;
  localparam logic [7:0] SEED_ZERO_SUB = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {^(x & LFSR_TAP), x[7:1]};
  endfunction

endpackage

// File: rtl/rand_arb_if.sv
// Requester-side bus of rand_arb: draw handshake, reseed port and live LFSR view.
interface rand_arb_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       seed_we;
  logic [7:0] seed_data;
  logic       busy;
  logic [7:0] cur;

  modport master (
    output req, seed_we, seed_data,
    input  gnt, ack, rdata, busy, cur
  );

  modport slave (
    input  req, seed_we, seed_data,
    output gnt, ack, rdata, busy, cur
  );
endinterface

// File: rtl/rand_arb_lfsr8.sv
// 8-bit Fibonacci LFSR with seed load; a zero seed is replaced so the register never locks up.
module lfsr8
  import rand_arb_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q
);

  logic [7:0] x_r;

  // LFSR state: load beats step
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x_r <= SEED;
    end else if (load) begin
      x_r <= (load_val == 8'h00) ? SEED_ZERO_SUB : load_val;
    end else if (step) begin
      x_r <= lfsr_next(x_r);
    end else begin
      x_r <= x_r;
    end
  end

  assign q = x_r;

endmodule

// File: rtl/rand_arb.sv
// Round-robin server of LFSR bytes to two requesters; each draw advances the LFSR STEPS times.
module rand_arb
  import rand_arb_pkg::*;
#(
  parameter logic [7:0] SEED  = 8'h01,
  parameter int         STEPS = 8
) (
  input  logic        clk,
  input  logic        clr,
  rand_arb_if.slave   bus
);

  localparam logic [3:0] LAST_CNT = 4'(STEPS - 1);

  state_t     state_r, state_s;
  logic [3:0] cnt_r;
  logic       owner_r, owner_s, pick_s, last_r;
  logic [1:0] gnt_r, gnt_s, ack_r, ack_s;
  logic       busy_r, busy_s;
  logic [7:0] rdata_r, cur_s;
  logic       step_s, load_s;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .clr      (clr),
    .step     (step_s),
    .load     (load_s),
    .load_val (bus.seed_data),
    .q        (cur_s)
  );

  // State register plus counter, pointer and output registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
      gnt_r   <= 2'b00;
      ack_r   <= 2'b00;
      busy_r  <= 1'b0;
      rdata_r <= 8'h00;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      gnt_r   <= gnt_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
      cnt_r   <= (state_r == SHIFT) ? cnt_r + 4'd1 : 4'd0;
      last_r  <= (state_r == ACK) ? owner_r : last_r;
      // Capture the value the final step produces, in step with the move to ACK
      rdata_r <= (state_r == SHIFT && state_s == ACK) ? lfsr_next(cur_s) : rdata_r;
    end
  end

  // Next-state and round-robin pick
  always_comb begin
    state_s = state_r;
    if (bus.req == 2'b11) begin
      pick_s = ~last_r;
    end else begin
      pick_s = bus.req[1];
    end
    case (state_r)
      IDLE: begin
        if (bus.seed_we) begin
          state_s = IDLE;
        end else if (bus.req != 2'b00) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT:   state_s = (cnt_r == LAST_CNT) ? ACK : SHIFT;
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs
  always_comb begin
    load_s  = (state_r == IDLE) && bus.seed_we;
    step_s  = (state_r == SHIFT);
    owner_s = (state_r == IDLE && state_s == SHIFT) ? pick_s : owner_r;
    if (state_s != IDLE) begin
      gnt_s  = owner_s ? 2'b10 : 2'b01;
      busy_s = 1'b1;
    end else begin
      gnt_s  = 2'b00;
      busy_s = 1'b0;
    end
    ack_s = (state_s == ACK) ? gnt_s : 2'b00;
  end

  assign bus.gnt   = gnt_r;
  assign bus.ack   = ack_r;
  assign bus.busy  = busy_r;
  assign bus.rdata = rdata_r;
  assign bus.cur   = cur_s;

endmodule

// File: tb/tb_rand_arb.sv
// Directed bench for rand_arb: per-cycle vector table plus multi-cycle arbitration sequences.
module tb_rand_arb;
  logic clk;
  logic clr;
  int   total_cnt;
  int   pass_cnt;

  rand_arb_if bus ();

  rand_arb #(.SEED(8'h01), .STEPS(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       swe;
    logic [7:0] sdata;
    logic [1:0] gnt;
    logic [1:0] ack;
    logic       busy;
    logic [7:0] cur;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr           = 1'b1;
    bus.req       = 2'b00;
    bus.seed_we   = 1'b0;
    bus.seed_data = 8'h00;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int ack_cyc[4];
    int ack_own[4];
    int n_ack;
    int zero_seen;

    total_cnt = 0;
    pass_cnt  = 0;
    clr       = 1'b1;
    bus.req   = 2'b00;
    bus.seed_we   = 1'b0;
    bus.seed_data = 8'h00;

    //           req    swe   sdata  gnt    ack    busy  cur    rdata
    tbl[0]  = '{2'b00, 1'b1, 8'h00, 2'b00, 2'b00, 1'b0, 8'h01, 8'h00};
    tbl[1]  = '{2'b00, 1'b1, 8'hA5, 2'b00, 2'b00, 1'b0, 8'hA5, 8'h00};
    tbl[2]  = '{2'b01, 1'b1, 8'h01, 2'b00, 2'b00, 1'b0, 8'h01, 8'h00};
    tbl[3]  = '{2'b01, 1'b0, 8'h00, 2'b01, 2'b00, 1'b1, 8'h01, 8'h00};
    tbl[4]  = '{2'b01, 1'b0, 8'h00, 2'b01, 2'b00, 1'b1, 8'h80, 8'h00};
    tbl[5]  = '{2'b01, 1'b0, 8'h00, 2'b01, 2'b00, 1'b1, 8'h40, 8'h00};
    tbl[6]  = '{2'b01, 1'b1, 8'hFF, 2'b01, 2'b00, 1'b1, 8'h20, 8'h00};
    tbl[7]  = '{2'b01, 1'b0, 8'h00, 2'b01, 2'b00, 1'b1, 8'h10, 8'h00};
    tbl[8]  = '{2'b01, 1'b0, 8'h00, 2'b01, 2'b00, 1'b1, 8'h88, 8'h00};
    tbl[9]  = '{2'b01, 1'b0, 8'h00, 2'b01, 2'b00, 1'b1, 8'hC4, 8'h00};
    tbl[10] = '{2'b01, 1'b1, 8'h00, 2'b01, 2'b00, 1'b1, 8'hE2, 8'h00};
    tbl[11] = '{2'b01, 1'b0, 8'h00, 2'b01, 2'b01, 1'b1, 8'h71, 8'h71};
    tbl[12] = '{2'b00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h71, 8'h71};

    // Reset state
    do_reset();
    chk("rst_gnt",   {6'd0, bus.gnt},  8'h00);
    chk("rst_ack",   {6'd0, bus.ack},  8'h00);
    chk("rst_busy",  {7'd0, bus.busy}, 8'h00);
    chk("rst_cur",   bus.cur,          8'h01);
    chk("rst_rdata", bus.rdata,        8'h00);

    // Seeding, seed/request collision and one full draw
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.req       = tbl[i].req;
      bus.seed_we   = tbl[i].swe;
      bus.seed_data = tbl[i].sdata;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_gnt", i),   {6'd0, bus.gnt},  {6'd0, tbl[i].gnt});
      chk($sformatf("v%0d_ack", i),   {6'd0, bus.ack},  {6'd0, tbl[i].ack});
      chk($sformatf("v%0d_busy", i),  {7'd0, bus.busy}, {7'd0, tbl[i].busy});
      chk($sformatf("v%0d_cur", i),   bus.cur,          tbl[i].cur);
      chk($sformatf("v%0d_rdata", i), bus.rdata,        tbl[i].rdata);
    end

    // clr during the 4th SHIFT cycle, then a tie goes to req0
    do_reset();
    bus.req = 2'b01;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy_before", {7'd0, bus.busy}, 8'h01);
    chk("mid_cur_before",  bus.cur,          8'h20);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_gnt",  {6'd0, bus.gnt},  8'h00);
    chk("clr_ack",  {6'd0, bus.ack},  8'h00);
    chk("clr_busy", {7'd0, bus.busy}, 8'h00);
    chk("clr_cur",  bus.cur,          8'h01);
    @(negedge clk);
    clr     = 1'b0;
    bus.req = 2'b11;
    @(posedge clk);
    #1;
    chk("post_clr_gnt", {6'd0, bus.gnt}, 8'h01);

    // Round robin with both requesters: drop only in own ack cycle
    do_reset();
    bus.req = 2'b11;
    n_ack   = 0;
    for (int c = 1; c <= 60 && n_ack < 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.ack != 2'b00) begin
        ack_cyc[n_ack] = c;
        ack_own[n_ack] = int'(bus.ack[1]);
        n_ack++;
        bus.req = 2'b11 & ~bus.ack;
      end else begin
        bus.req = 2'b11;
      end
    end
    chk("rr_ack_count", 8'(n_ack), 8'd4);
    for (int k = 0; k < n_ack; k++) begin
      chk($sformatf("rr_owner%0d", k), 8'(ack_own[k]), 8'(k % 2));
      if (k > 0) begin
        chk($sformatf("rr_gap%0d", k), 8'(ack_cyc[k] - ack_cyc[k-1]), 8'd10);
      end
    end

    // 255 back-to-back draws by req0 walk the full LFSR period
    do_reset();
    bus.req   = 2'b01;
    n_ack     = 0;
    zero_seen = 0;
    for (int c = 0; c < 2600 && n_ack < 255; c++) begin
      @(posedge clk);
      #1;
      if (bus.cur == 8'h00) zero_seen++;
      if (bus.ack == 2'b01) begin
        n_ack++;
        if (bus.rdata == 8'h00) zero_seen++;
      end
    end
    chk("full_ack_count", 8'(n_ack), 8'd255);
    chk("full_zero_seen", 8'(zero_seen), 8'd0);
    chk("full_cur_wrap",  bus.cur,   8'h01);
    chk("full_rdata",     bus.rdata, 8'h01);
    bus.req = 2'b00;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rand_arb.md
# rand_arb

Arbitrated random-byte server that owns the 8-bit Fibonacci LFSR (feedback x[4]^x[3]^x[2]^x[0]) and shares it between two requesters. Each granted draw advances the LFSR 8 steps, so requesters receive non-overlapping bytes, and returns the result with a one-cycle acknowledge. The block also supports reseeding and exports the live LFSR value for the seven-segment display path (bcd7seg digits).

## Interface
- SEED, 8'h01, LFSR value after reset; must be non-zero.
- STEPS, 8, LFSR steps per draw (1..15).
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- req  in  2  per-requester draw request, level, held until ack.
- gnt  out  2  one-hot owner of the current draw, high during SHIFT and ACK.
- ack  out  2  one-cycle pulse to owner; rdata valid in same cycle.
- rdata  out  8  drawn byte, registered, holds last value between draws.
- seed_we  in  1  load seed_data into the LFSR (honoured only in IDLE).
- seed_data  in  8  seed value; 8'h00 is replaced by 8'h01.
- busy  out  1  high whenever state is not IDLE.
- cur  out  8  live LFSR state, for hex display.

## Operation
- LFSR step: x <= {x[4]^x[3]^x[2]^x[0], x[7:1]}; period 255; never reaches 0.
- FSM states: IDLE, SHIFT, ACK.
- IDLE + seed_we: x <= (seed_data==0 ? 8'h01 : seed_data); stay IDLE. seed_we outranks req, and pending req waits one cycle.
- IDLE + any req (no seed_we): pick owner round-robin. The requester not served last wins ties. last=1 after reset, so req0 wins the first tie. Latch owner, cnt<=0, go SHIFT.
- SHIFT: step LFSR every cycle, cnt++. When cnt==STEPS-1 (the final step), go ACK.
- ACK: ack[owner]=1, rdata = x (registered at SHIFT→ACK edge), last<=owner, go IDLE.
- Requester drops req mid-draw: draw still completes, ack still pulses, data is discarded. No abort.
- seed_we outside IDLE: ignored, no side effects.
- Reset values: state IDLE, x=SEED, cur=SEED, rdata=8'h00, gnt=0, ack=0, busy=0, cnt=0, last=1.

## Timing
- req sampled at IDLE edge E0 → gnt high from E0; steps at edges E1..E8 (STEPS=8); ack high in cycle after E8; IDLE again at E9.
- Latency from sampling edge to ack = STEPS+1 cycles; earliest next grant at E10. Throughput is 1 byte per STEPS+2 cycles.
- Requester must deassert req in the ack cycle, or a new draw is granted at E10.
- clr mid-operation (any state): all outputs forced to reset values immediately. The in-flight draw is lost with no ack.
- cur reflects x combinationally from the register, updating every SHIFT edge.

## Structure
- Package rand_arb_pkg: state enum (IDLE, SHIFT, ACK), LFSR_TAP mask 8'b0001_1101, SEED_ZERO_SUB 8'h01.
- Sub-module lfsr8: inputs clk, clr, step, load, load_val; output q. Applies the zero-seed substitution and the reset value SEED.
- Top holds FSM, step counter, round-robin pointer, and output registers.

## Test plan
- After clr, req=2'b01 held: gnt=01 for 9 cycles; ack=01 at cycle 9 with rdata=8'h71 (01→80→40→20→10→88→C4→E2→71); cur=8'h71 afterward.
- req=2'b11 held from clr, each requester dropping req only in its ack cycle then reasserting: ack order 0,1,0,1; consecutive acks exactly 10 cycles apart.
- IDLE, seed_we with seed_data=8'h00 → cur=8'h01. Then seed_data=8'hA5 → cur=8'hA5 next cycle; busy stays 0.
- seed_we and req0 at the same IDLE edge: cur=seed, grant on the following edge; rdata equals the seed advanced 8 steps.
- clr pulsed during 4th SHIFT cycle: gnt/ack/busy drop immediately, cur=8'h01. Then req=2'b11 grants req0 first.
- 255 back-to-back draws by req0 from reset: no rdata/cur ever 8'h00; cur returns to 8'h01 after the 255th draw.
